// File: rtl/adder_pkg.sv
// Shared definitions for the adder_accum slice: operation encoding.
package adder_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_ADD = 2'b00;
  localparam op_t OP_SUB = 2'b01;
  localparam op_t OP_ACC = 2'b10;
  localparam op_t OP_CLR = 2'b11;

endpackage

// File: rtl/adder_fifo.sv
// Synchronous result FIFO; head data is read straight from the storage registers.
module adder_fifo #(
  parameter int unsigned DW    = 5,
  parameter int unsigned DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/adder_accum.sv
// Registered add/sub/accumulate unit with valid/ready handshakes, sticky overflow
// and an output FIFO holding results until the consumer takes them.
module adder_accum
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned SAT   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ena,
  input  logic             in_valid,
  output logic             in_ready,
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   z,
  output logic [WIDTH-1:0] acc,
  output logic             ovf
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   res;
  logic [WIDTH:0]   sum;
  logic             fifo_full, fifo_empty;
  logic             push, pop;

  // Ready depends only on registered occupancy, never on out_ready.
  assign in_ready  = ena && !fifo_full;
  assign out_valid = ena && !fifo_empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign acc = acc_q;
  assign ovf = ovf_q;
  assign sum = {1'b0, acc_q} + {1'b0, a};

  always_comb begin
    res   = '0;
    acc_d = acc_q;
    ovf_d = ovf_q;
    case (op)
      OP_ADD: res = {1'b0, a} + {1'b0, b};
      OP_SUB: res = {1'b0, a} - {1'b0, b};
      OP_ACC: begin
        if ((SAT != 0) && sum[WIDTH]) res = {1'b1, {WIDTH{1'b1}}};
        else                          res = sum;
      end
      default: res = '0;
    endcase
    if (push) begin
      if (op == OP_ACC) acc_d = res[WIDTH-1:0];
      if (op == OP_CLR) begin
        acc_d = '0;
        ovf_d = 1'b0;
      end else begin
        ovf_d = ovf_q | res[WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  adder_fifo #(
    .DW   (WIDTH + 1),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (push),
    .pop_i  (pop),
    .wdata_i(res),
    .rdata_o(z),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

endmodule

// File: tb/tb_adder_accum.sv
// Scoreboard bench: wrap (SAT=0) and saturating (SAT=1) instances share stimulus,
// each checked against an arithmetic reference model and an expected-result queue.
module tb_adder_accum;

  localparam int unsigned W = 4;
  localparam int unsigned D = 2;

  logic         clk = 1'b0;
  logic         reset, ena, in_valid, out_ready;
  logic [1:0]   op;
  logic [W-1:0] a, b;

  logic         in_ready_w  [2];
  logic         out_valid_w [2];
  logic         ovf_w       [2];
  logic [W:0]   z_w         [2];
  logic [W-1:0] acc_w       [2];

  int checks = 0;
  int failures = 0;

  int         macc [2];
  bit         movf [2];
  logic [W:0] expq [2][$];
  bit         z0_pend = 1'b1;
  bit         done;

  always #5 clk = ~clk;

  adder_accum #(.WIDTH(W), .DEPTH(D), .SAT(0)) u_wrap (
    .clk(clk), .reset(reset), .ena(ena), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .op(op), .a(a), .b(b), .out_valid(out_valid_w[0]), .out_ready(out_ready),
    .z(z_w[0]), .acc(acc_w[0]), .ovf(ovf_w[0])
  );

  adder_accum #(.WIDTH(W), .DEPTH(D), .SAT(1)) u_sat (
    .clk(clk), .reset(reset), .ena(ena), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .op(op), .a(a), .b(b), .out_valid(out_valid_w[1]), .out_ready(out_ready),
    .z(z_w[1]), .acc(acc_w[1]), .ovf(ovf_w[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares flags, acc/ovf and popped results, then advances the model.
  bit         full_m;
  int         s;
  logic [W:0] e, zz;
  always @(negedge clk) begin
    full_m = (expq[0].size() >= int'(D));
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("acc%0d", d), 32'(acc_w[d]), 32'(macc[d]));
      chk($sformatf("ovf%0d", d), 32'(ovf_w[d]), 32'(movf[d]));
      chk($sformatf("in_ready%0d", d), 32'(in_ready_w[d]), 32'(ena && !full_m));
      chk($sformatf("out_valid%0d", d), 32'(out_valid_w[d]), 32'(ena && expq[d].size() > 0));
      if (z0_pend) chk($sformatf("z_reset%0d", d), 32'(z_w[d]), 32'(0));
      if (!reset && ena && out_ready && expq[d].size() > 0) begin
        e = expq[d].pop_front();
        chk($sformatf("z%0d", d), 32'(z_w[d]), 32'(e));
      end
    end
    z0_pend = 1'b0;
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        expq[d].delete();
        macc[d] = 0;
        movf[d] = 1'b0;
      end
      z0_pend = 1'b1;
    end else if (in_valid && ena && !full_m) begin
      for (int d = 0; d < 2; d++) begin
        case (op)
          2'd0: zz = (W+1)'(a + b);
          2'd1: zz = (a >= b) ? (W+1)'(a - b) : (W+1)'(32 + int'(a) - int'(b));
          2'd2: begin
            s = macc[d] + int'(a);
            if (d == 1 && s > 15) begin
              macc[d] = 15;
              zz = 5'd31;
            end else begin
              macc[d] = s % 16;
              zz = (W+1)'(s);
            end
          end
          default: begin
            zz = '0;
            macc[d] = 0;
            movf[d] = 1'b0;
          end
        endcase
        if (zz >= 16) movf[d] = 1'b1;
        expq[d].push_back(zz);
      end
    end
  end

  task automatic send(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    bool_wait : begin
      in_valid = 1'b1; op = o; a = x; b = y;
      for (int n = 0; n < 200; n++) begin
        @(negedge clk);
        if (in_ready_w[0]) begin
          @(posedge clk); #1;
          in_valid = 1'b0;
          disable bool_wait;
        end
      end
      checks++;
      failures++;
      $display("FAIL send_timeout actual=no_accept required=accept op=%0d", o);
      in_valid = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op = 2'd0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Basic ADD/SUB, then wrap/saturate accumulate and CLR.
    send(2'd0, 4'd9, 4'd8);
    send(2'd1, 4'd3, 4'd5);
    send(2'd2, 4'd15, 4'd0);
    send(2'd2, 4'd3, 4'd0);
    chk("wrap_acc", 32'(acc_w[0]), 32'd2);
    chk("sat_acc", 32'(acc_w[1]), 32'd15);
    chk("ovf_set", 32'(ovf_w[0]), 32'd1);
    send(2'd3, 4'd7, 4'd7);
    chk("clr_acc", 32'(acc_w[1]), 32'd0);
    chk("clr_ovf", 32'(ovf_w[1]), 32'd0);
    repeat (3) @(posedge clk);
    #1;

    // Back-pressure: third beat held until the FIFO leaves full.
    out_ready = 1'b0;
    fork
      begin
        send(2'd0, 4'd1, 4'd2);
        send(2'd1, 4'd8, 4'd1);
        send(2'd2, 4'd4, 4'd0);
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        chk("bp_in_ready", 32'(in_ready_w[0]), 32'd0);
        out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;

    // Steady state push/pop at occupancy one.
    for (int i = 0; i < 11; i++)
      send(2'($urandom_range(0, 2)), 4'($urandom), 4'($urandom));
    repeat (3) @(posedge clk);
    #1;

    // Freeze with one entry queued.
    out_ready = 1'b0;
    send(2'd0, 4'd6, 4'd7);
    ena = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("freeze_out_valid", 32'(out_valid_w[0]), 32'd0);
    ena = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset mid-stream with a full FIFO.
    out_ready = 1'b0;
    send(2'd2, 4'd5, 4'd0);
    send(2'd2, 4'd6, 4'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_acc", 32'(acc_w[0]), 32'd0);
    chk("rst_out_valid", 32'(out_valid_w[0]), 32'd0);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Random traffic with random back-pressure and enable.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++)
          send(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom));
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
          ena = ($urandom_range(0, 7) != 0);
        end
      end
    join

    ena = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && expq[0].size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", 32'(expq[0].size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_accum.md
# adder_accum

Parametrised successor to the 4-bit combinational adder: a registered add/subtract/accumulate unit with valid/ready handshakes on both sides and a small output FIFO. It sits between an operand source and a result consumer in the same clock domain. It adds an internal accumulator, a sticky overflow flag, optional saturation and back-pressure, none of which the combinational predecessor has.

## Interface
Parameters:
- WIDTH, 4: operand and accumulator width in bits; WIDTH >= 2.
- DEPTH, 2: output FIFO depth in entries; power of two, >= 2.
- SAT, 0: accumulator mode. 0 = wrap, 1 = saturate at all-ones.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ena  in  1  global enable. When low, the block is frozen: in_ready=0, out_valid=0, no state changes.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  equals ena && !fifo_full.
- op  in  2  operation: 00 ADD, 01 SUB, 10 ACC, 11 CLR.
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned; ignored for ACC and CLR.
- out_valid  out  1  equals ena && !fifo_empty.
- out_ready  in  1  consumer accepts the head result.
- z  out  WIDTH+1  head result; bit WIDTH is carry or borrow.
- acc  out  WIDTH  current accumulator value (registered).
- ovf  out  1  sticky overflow flag.

## Operation
- Accept condition: in_valid && in_ready. Exactly one result is pushed per accepted beat.
- ADD: z = {carry, a+b}, i.e. the full WIDTH+1 sum.
- SUB: z[WIDTH-1:0] = (a-b) mod 2^WIDTH; z[WIDTH] = borrow (a<b).
- ACC:
  - The full sum s = acc + a is computed at WIDTH+1 bits.
  - SAT=0: acc <= s[WIDTH-1:0]; z = s.
  - SAT=1: if s[WIDTH] is set, acc <= all-ones and z = {1, all-ones}; otherwise acc <= s and z = s.
- CLR: acc <= 0, ovf <= 0, z = 0.
- ovf is set on any accepted beat whose z[WIDTH]=1. It is cleared only by CLR or reset.
- Pop condition: out_valid && out_ready. Pops the FIFO head.
- Push and pop in the same cycle are both allowed. The occupancy count is unchanged when both happen.
- The FIFO is full when it holds DEPTH entries. A full FIFO drops in_ready even if a pop happens in the same cycle; there is no combinational pass-through from out_ready to in_ready.
- While the FIFO is full, in_valid is ignored and no state changes.

## Timing
- Latency: a beat accepted at edge N appears on z with out_valid=1 after edge N, provided the FIFO was empty.
- z is a registered FIFO read. It is stable while out_valid=1 && out_ready=0.
- acc and ovf update on the accepting edge. A back-to-back ACC on the next cycle uses the updated acc, so there is no hazard bubble and full throughput is one beat per cycle.
- Reset values: acc=0, ovf=0, FIFO empty, out_valid=0, z=0.
- in_ready=1 in the first cycle after reset deassertion when ena=1.
- Reset asserted mid-stream flushes all FIFO contents on that edge. Any in-flight handshake that cycle is discarded.
- ena low freezes the block; on re-enable it resumes with the same FIFO contents and acc.
- Priority: reset > ena low > normal operation.

## Structure
- Package adder_pkg holds:
  - the op encoding constants OP_ADD, OP_SUB, OP_ACC, OP_CLR;
  - the op_t typedef (2 bits).
- Sub-module adder_fifo: a synchronous FIFO parametrised by data width (WIDTH+1) and DEPTH.
  - Read/write pointers are log2(DEPTH) bits plus a count.
  - Provides full, empty, push, pop and head data.
- The top level contains the operation datapath, the accumulator register and the ovf flag.

## Test plan
All scenarios use WIDTH=4, DEPTH=2.
- ADD and SUB, SAT=0:
  - ADD a=9, b=8 -> z=5'h11.
  - SUB a=3, b=5 -> z=5'b1_1110, ovf=1.
- Wrap: ACC a=15 from acc=0, then ACC a=3 with SAT=0 -> z=0x0F then 0x12; acc=2; ovf=1. CLR -> acc=0, ovf=0, z=0.
- Saturation: same sequence with SAT=1 -> second result z=0x1F; acc=15; ovf=1.
- Back-pressure:
  - Hold out_ready=0 and push 3 beats -> in_ready drops after 2 accepted; the 3rd beat is held.
  - Release out_ready -> results drain in order, and the 3rd beat is accepted once the FIFO leaves full.
- Simultaneous push/pop at count=1 across 10 consecutive cycles -> count stays 1; results are in order with no loss.
- Freeze and reset:
  - Drop ena with 1 entry queued -> out_valid=0 and acc unchanged; the entry reappears on re-enable.
  - Reset mid-stream -> FIFO empty, acc=0, z=0 on the next cycle.
